// File: rtl/data_bus_control_if.sv
// Load/store bus between the RV32I load/store path (master) and the data RAM
// controller (slave).
interface data_bus_control_if;
  logic        wd;
  logic        rd;
  logic [1:0]  size_in;
  logic [1:0]  size_out;
  logic [31:0] addr_in;
  logic [31:0] addr_out;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        busy;

  modport master (
    output wd, rd, size_in, size_out, addr_in, addr_out, data_in,
    input  data_out, ready, busy
  );

  modport slave (
    input  wd, rd, size_in, size_out, addr_in, addr_out, data_in,
    output data_out, ready, busy
  );
endinterface

// File: rtl/data_bus_control.sv
// Data-side RAM controller: clears the RAM after reset, then serves
// combinational byte/half/word loads and clock-edge byte-lane stores.
module data_bus_control #(
  parameter int          DATA_ADDR_WIDTH = 10,
  parameter logic [31:0] DATA_BASE       = 32'h0000_0000
) (
  input  logic i_clk,
  input  logic i_rst_n,
`ifdef RISCUIN_DUMP
  input  logic i_dump,
`endif
  data_bus_control_if.slave bus
);

  localparam int N     = DATA_ADDR_WIDTH;
  localparam int DEPTH = 1 << N;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t      r_state;
  logic [N-1:0] r_clearIdx;
  logic        r_ready;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]  w_stOff;
  logic [31:0]  w_ldOff;
  logic         w_stHit;
  logic         w_ldHit;
  logic         w_memWe;
  logic [N-1:0] w_memIdx;
  logic [3:0]   w_memBe;
  logic [31:0]  w_memData;
  logic [31:0]  w_ldWord;
  logic [31:0]  w_dataOut;

  // Size 11 is treated as a word, so anything that is not byte/half needs lane 00.
  function automatic logic alignedF(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   alignedF = 1'b1;
      2'b01:   alignedF = ~lane[0];
      default: alignedF = (lane == 2'b00);
    endcase
  endfunction

  assign w_stOff = bus.addr_in  - DATA_BASE;
  assign w_ldOff = bus.addr_out - DATA_BASE;
  assign w_stHit = (bus.addr_in  >= DATA_BASE) && (w_stOff[31:N+2] == '0);
  assign w_ldHit = (bus.addr_out >= DATA_BASE) && (w_ldOff[31:N+2] == '0);

  always_comb begin
    w_memWe   = 1'b0;
    w_memIdx  = w_stOff[N+1:2];
    w_memBe   = 4'b0000;
    w_memData = 32'h0;
    if (r_state == ST_CLEAR) begin
      w_memWe  = 1'b1;
      w_memIdx = r_clearIdx;
      w_memBe  = 4'b1111;
    end else if (bus.wd && w_stHit && alignedF(bus.size_in, w_stOff[1:0])) begin
      w_memWe = 1'b1;
      case (bus.size_in)
        2'b00: begin
          w_memBe   = 4'b0001 << w_stOff[1:0];
          w_memData = {4{bus.data_in[7:0]}};
        end
        2'b01: begin
          w_memBe   = w_stOff[1] ? 4'b1100 : 4'b0011;
          w_memData = {2{bus.data_in[15:0]}};
        end
        default: begin
          w_memBe   = 4'b1111;
          w_memData = bus.data_in;
        end
      endcase
    end
  end

  // Lanes are replicated above, so each enabled byte just takes its own slice.
  always_ff @(posedge i_clk) begin
    if (w_memWe) begin
      for (int k = 0; k < 4; k++) begin
        if (w_memBe[k]) r_mem[w_memIdx][8*k +: 8] <= w_memData[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_clearIdx <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clearIdx <= r_clearIdx + 1'b1;
          if (r_clearIdx == '1) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_ldWord = r_mem[w_ldOff[N+1:2]];

  // Loads see the pre-edge word, giving read-before-write on a same-cycle store.
  always_comb begin
    w_dataOut = 32'h0;
    if (r_ready && bus.rd && w_ldHit && alignedF(bus.size_out, w_ldOff[1:0])) begin
      case (bus.size_out)
        2'b00:   w_dataOut = {24'h0, w_ldWord[{w_ldOff[1:0], 3'b000} +: 8]};
        2'b01:   w_dataOut = {16'h0, (w_ldOff[1] ? w_ldWord[31:16] : w_ldWord[15:0])};
        default: w_dataOut = w_ldWord;
      endcase
    end
  end

  assign bus.data_out = w_dataOut;
  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;

`ifdef RISCUIN_DUMP
  logic r_dumpQ;
  always_ff @(posedge i_clk) begin
    r_dumpQ <= i_dump;
  end
`endif

endmodule

// File: tb/tb_data_bus_control.sv
// Directed bench for data_bus_control with a 16-word RAM: clear sweep,
// byte/half/word stores and loads, misalignment, range and read-before-write.
module tb_data_bus_control;

  logic clk;
  logic rst_n;
  int   totalChecks;
  int   passCount;

  data_bus_control_if bus();

  data_bus_control #(
    .DATA_ADDR_WIDTH(4),
    .DATA_BASE      (32'h0000_0000)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
`ifdef RISCUIN_DUMP
    .i_dump (1'b0),
`endif
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic wd, input logic rd,
                               input logic [1:0] sizeIn, input logic [1:0] sizeOut,
                               input logic [31:0] addrIn, input logic [31:0] addrOut,
                               input logic [31:0] dataIn);
    bus.wd       = wd;
    bus.rd       = rd;
    bus.size_in  = sizeIn;
    bus.size_out = sizeOut;
    bus.addr_in  = addrIn;
    bus.addr_out = addrOut;
    bus.data_in  = dataIn;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, size, 2'b10, addr, 32'h0, data);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [1:0] size, input logic [31:0] addr);
    applyStimulus(1'b0, 1'b1, 2'b10, size, 32'h0, addr, 32'h0);
  endtask

  // Runs a full 16-edge sweep, checking ready/busy just before and after the last edge.
  task automatic sweepAndCheck(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        checkOutput({tag, "_ready_edge15"}, {31'h0, bus.ready}, 32'h0);
        checkOutput({tag, "_busy_edge15"},  {31'h0, bus.busy},  32'h1);
        applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0);
      end
    end
    checkOutput({tag, "_ready_edge16"}, {31'h0, bus.ready}, 32'h1);
    checkOutput({tag, "_busy_edge16"},  {31'h0, bus.busy},  32'h0);
  endtask

  initial begin
    totalChecks = 0;
    passCount   = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0);
    #11;
    checkOutput("rst_ready", {31'h0, bus.ready}, 32'h0);
    checkOutput("rst_busy",  {31'h0, bus.busy},  32'h1);
    rst_n = 1'b1;

    // Stores to word 0 and loads from word 15 are attempted during the sweep.
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b10, 32'h0, 32'h3C, 32'hFFFF_FFFF);
    sweepAndCheck("init");

    load(2'b10, 32'h0);
    checkOutput("load0_after_init", bus.data_out, 32'h0);

    store(2'b10, 32'h10, 32'hDEAD_BEEF);
    load(2'b10, 32'h10);
    checkOutput("word_load_10", bus.data_out, 32'hDEAD_BEEF);
    load(2'b00, 32'h13);
    checkOutput("byte_load_13", bus.data_out, 32'h0000_00DE);
    load(2'b00, 32'h10);
    checkOutput("byte_load_10", bus.data_out, 32'h0000_00EF);
    load(2'b01, 32'h12);
    checkOutput("half_load_12", bus.data_out, 32'h0000_DEAD);

    store(2'b00, 32'h11, 32'h0000_00AA);
    store(2'b01, 32'h12, 32'hFFFF_1234);
    load(2'b10, 32'h10);
    checkOutput("merge_word_10", bus.data_out, 32'h1234_AAEF);

    store(2'b01, 32'h11, 32'h0000_5555);
    store(2'b10, 32'h40, 32'h1111_1111);
    load(2'b10, 32'h10);
    checkOutput("misaligned_store_drop", bus.data_out, 32'h1234_AAEF);
    load(2'b10, 32'h0);
    checkOutput("oor_store_drop", bus.data_out, 32'h0);
    load(2'b10, 32'h12);
    checkOutput("misaligned_word_load", bus.data_out, 32'h0);
    load(2'b01, 32'h11);
    checkOutput("misaligned_half_load", bus.data_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h10, 32'h0);
    checkOutput("rd_low_zero", bus.data_out, 32'h0);

    applyStimulus(1'b1, 1'b1, 2'b10, 2'b10, 32'h10, 32'h10, 32'hA5A5_5A5A);
    checkOutput("rbw_old_value", bus.data_out, 32'h1234_AAEF);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b10, 32'h0, 32'h10, 32'h0);
    checkOutput("rbw_new_value", bus.data_out, 32'hA5A5_5A5A);

    store(2'b00, 32'h1F, 32'h0000_0077);
    load(2'b10, 32'h1C);
    checkOutput("byte_lane3", bus.data_out, 32'h7700_0000);
    store(2'b11, 32'h14, 32'h0102_0304);
    load(2'b11, 32'h14);
    checkOutput("size11_word", bus.data_out, 32'h0102_0304);
    load(2'b11, 32'h16);
    checkOutput("size11_misaligned", bus.data_out, 32'h0);
    load(2'b01, 32'h16);
    checkOutput("half_upper_16", bus.data_out, 32'h0000_0102);

    // Word 12 holds data across a reset so ready gating and clearing are visible.
    store(2'b10, 32'h30, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst2_ready", {31'h0, bus.ready}, 32'h0);
    checkOutput("rst2_busy",  {31'h0, bus.busy},  32'h1);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    load(2'b10, 32'h30);
    checkOutput("sweep_load_gated", bus.data_out, 32'h0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midsweep_ready", {31'h0, bus.ready}, 32'h0);
    #4 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0);
    sweepAndCheck("restart");
    load(2'b10, 32'h30);
    checkOutput("cleared_word_30", bus.data_out, 32'h0);
    load(2'b10, 32'h10);
    checkOutput("cleared_word_10", bus.data_out, 32'h0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
